copro_mailbox: RTL and testbench
================================

// Module: copro_mailbox
// PURPOSE
//  Parametrised two-way mailbox between host CPU (C64, I/O2 window) and 6809 coprocessor.
//  Two independent FIFOs (host->copro H2C, copro->host C2H) with status, sticky error flags and
//  level-sensitive active-low interrupts to each side (replaces tied-off _irq_09).
//  Sits beside the shared-RAM window logic; both bus sides present pre-decoded 1-cycle strobes in the clock domain.
// PARAMETERS
//  WIDTH       8   data width of FIFO entries and register bus
//  DEPTH_LOG2  4   log2 of each FIFO depth (depth 16 by default); count fields are DEPTH_LOG2+1 bits
//  NMI_PULSE   4   NMI low-pulse length in clock cycles (COPRO_MAILBOX_NMI_EN only); legal range 1..255
// PORTS
//  clock        in   1      single system clock; all logic rising-edge
//  _reset       in   1      asynchronous active-low reset
//  h_wr/h_rd    in   1      host write/read strobes, one clock wide, mutually exclusive
//  h_addr       in   2      host register select
//  h_wdata      in   WIDTH  host write data
//  h_rdata      out  WIDTH  host read data, registered
//  c_wr/c_rd    in   1      6809 write/read strobes, one clock wide
//  c_addr       in   2      6809 register select
//  c_wdata      in   WIDTH  6809 write data
//  c_rdata      out  WIDTH  6809 read data, registered
//  _irq_host    out  1      active-low interrupt to host
//  _irq_09      out  1      active-low interrupt to 6809
//  _nmi_09      out  1      active-low NMI to 6809 (constant 1 without COPRO_MAILBOX_NMI_EN)
// BEHAVIOUR
//  Register map, per side; RX = FIFO read by that side, TX = FIFO written by that side:
//   0 DATA   wr: push TX; rd: pop RX
//   1 STAT   rd: [0] rx_nempty [1] tx_nfull [2] rx_ovf [3] rx_unf [4] tx_empty
//            wr: 1 to bit2/bit3 clears the sticky flag; other bits ignored
//   2 IEN    rd/wr: [0] irq on rx_nempty, [1] irq on tx_empty; upper bits read 0
//   3 COUNT  rd: RX entry count, zero-extended; host wr: doorbell (NMI option), 6809 wr ignored
//  Read data: rdata valid the cycle after the rd strobe; holds until the next rd strobe.
//  Pop: the popped entry appears on rdata one cycle after rd; pointer and count update same edge.
//  Push when TX full: data dropped, TX FIFO unchanged; the receiving side's rx_ovf sets.
//  Pop when RX empty: rdata = 0, pointers unchanged, that side's rx_unf sets.
//  Same-cycle push (one side) and pop (other side) on one FIFO:
//   not empty -> both occur, count unchanged; empty -> pop underflows, push succeeds (no bypass).
//   full -> pop succeeds, push succeeds (no overflow).
//  Sticky set and clear in the same cycle: set wins.
//  Pointers are DEPTH_LOG2 bits with natural wrap; count 0..2**DEPTH_LOG2.
//  _irq_x = !((ien[0] & rx_nempty) | (ien[1] & tx_empty)); combinational from registered state, glitch-free.
//  Reset (async assert, sync release handled upstream): FIFOs empty, flags 0, IEN 0,
//   rdata 0, _irq_host = _irq_09 = _nmi_09 = 1, NMI counter idle.
// CONFIGURATION
//  COPRO_MAILBOX_NMI_EN defined: host write to addr 3 (any data) loads the NMI counter with NMI_PULSE.
//   _nmi_09 is low while the counter is nonzero and is registered.
//   A doorbell during an active pulse restarts the count (single extended pulse, no second edge).
//  Not defined: _nmi_09 = 1 constantly; host addr-3 writes have no effect; no counter logic.
// STRUCTURE
//  copro_mailbox_defs.vh: register address localparams (REG_DATA/STAT/IEN/COUNT), STAT/IEN bit indices.
//  Sub-module mailbox_fifo (WIDTH, DEPTH_LOG2): push/pop/din/dout/count/full/empty, registered dout.
//   Instantiated twice (h2c, c2h).
//  Top level holds the per-side register decode, sticky flags, IEN, IRQ logic and the optional NMI counter.
// TESTING
//  1. Reset; read both STAT -> 0x12 (tx_nfull, tx_empty); _irq_* = 1.
//  2. Host pushes 0xA5, 0x5A; 6809 COUNT = 2; two pops -> 0xA5 then 0x5A; STAT bit0 = 0.
//  3. Host pushes 17 entries at DEPTH_LOG2=4 -> 6809 STAT bit2 = 1, COUNT = 16.
//     6809 writes STAT 0x04 -> bit2 = 0.
//  4. 6809 IEN = 0x01, host pushes 0x33 -> _irq_09 low the cycle after push.
//     6809 pop -> _irq_09 high after pop.
//  5. FIFO full; same-cycle host push 0x77 and 6809 pop -> no overflow, count stays 16.
//     0x77 is read last.
//  6. NMI_EN: host writes addr 3 -> _nmi_09 low exactly 4 cycles.
//     Second doorbell at cycle 2 -> low for 6 cycles total.
//     Assert _reset mid-pulse -> _nmi_09 = 1 immediately.

Source files
------------

// File: rtl/copro_mailbox_pkg.sv
// Shared definitions for the host <-> 6809 mailbox.
// Holds the register addresses and the bit positions inside STAT and IEN.
package copro_mailbox_pkg;

    // Register select values, the same on both bus sides
    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_STAT  = 2'd1;
    localparam logic [1:0] REG_IEN   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    // STAT bit positions
    localparam int STAT_RX_NEMPTY = 0;
    localparam int STAT_TX_NFULL  = 1;
    localparam int STAT_RX_OVF    = 2;
    localparam int STAT_RX_UNF    = 3;
    localparam int STAT_TX_EMPTY  = 4;

    // IEN bit positions
    localparam int IEN_RX_NEMPTY = 0;
    localparam int IEN_TX_EMPTY  = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// Single-clock FIFO used for each mailbox direction.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
// Pop of an empty FIFO loads zero into dout and leaves the pointers alone.
// There is no bypass: a push into an empty FIFO is not visible to a same-cycle pop.
module mailbox_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  _reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Count reaches exactly DEPTH when full, so the top bit alone marks it
    assign full  = count_q[DEPTH_LOG2];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    // Accept/reject decisions and next pointer, count and output values
    always_comb begin
        push_ok  = push & (~full | pop);
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (pop) begin
            dout_d = pop_ok ? mem_q[rd_ptr_q] : '0;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer, count and read-data registers
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/copro_mailbox.sv
// Two-way mailbox between the host CPU (I/O2 window) and the 6809 coprocessor.
// H2C FIFO carries host writes to the 6809, C2H FIFO carries 6809 writes to the host.
// Each side sees DATA / STAT / IEN / COUNT, sticky overflow/underflow flags and a
// level-sensitive active-low interrupt.
// Optional feature: define COPRO_MAILBOX_NMI_EN to make a host write to COUNT
// act as a doorbell that pulses _nmi_09 low for NMI_PULSE clocks.
module copro_mailbox
    import copro_mailbox_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int NMI_PULSE  = 4
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic             h_wr,
    input  logic             h_rd,
    input  logic [1:0]       h_addr,
    input  logic [WIDTH-1:0] h_wdata,
    output logic [WIDTH-1:0] h_rdata,
    input  logic             c_wr,
    input  logic             c_rd,
    input  logic [1:0]       c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    output logic [WIDTH-1:0] c_rdata,
    output logic             _irq_host,
    output logic             _irq_09,
    output logic             _nmi_09
);

    localparam int CW = DEPTH_LOG2 + 1;

    // Elaboration-time guards on the parameters
    if (NMI_PULSE < 1 || NMI_PULSE > 255) begin : g_bad_nmi_pulse
        $error("copro_mailbox: NMI_PULSE must be 1..255");
    end
    if (CW > WIDTH) begin : g_bad_width
        $error("copro_mailbox: COUNT field does not fit in WIDTH");
    end

    // FIFO interface
    logic             h_push, h_pop, c_push, c_pop;
    logic [WIDTH-1:0] h2c_dout, c2h_dout;
    logic [CW-1:0]    h2c_count, c2h_count;
    logic             h2c_full, h2c_empty, c2h_full, c2h_empty;

    // Per-side state
    logic [1:0]       h_ien_q, h_ien_d, c_ien_q, c_ien_d;
    logic             h_ovf_q, h_ovf_d, h_unf_q, h_unf_d;
    logic             c_ovf_q, c_ovf_d, c_unf_q, c_unf_d;
    logic             h_rsel_q, h_rsel_d, c_rsel_q, c_rsel_d;
    logic [WIDTH-1:0] h_rreg_q, h_rreg_d, c_rreg_q, c_rreg_d;

    assign h_push = h_wr & (h_addr == REG_DATA);
    assign h_pop  = h_rd & (h_addr == REG_DATA);
    assign c_push = c_wr & (c_addr == REG_DATA);
    assign c_pop  = c_rd & (c_addr == REG_DATA);

    mailbox_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_h2c (
        .clock (clock),
        ._reset(_reset),
        .push  (h_push),
        .pop   (c_pop),
        .din   (h_wdata),
        .dout  (h2c_dout),
        .count (h2c_count),
        .full  (h2c_full),
        .empty (h2c_empty)
    );

    mailbox_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_c2h (
        .clock (clock),
        ._reset(_reset),
        .push  (c_push),
        .pop   (h_pop),
        .din   (c_wdata),
        .dout  (c2h_dout),
        .count (c2h_count),
        .full  (c2h_full),
        .empty (c2h_empty)
    );

    // Register read mux for everything except DATA (DATA comes straight from the FIFO dout)
    function automatic logic [WIDTH-1:0] reg_read(
        input logic [1:0]    addr,
        input logic          rx_nempty,
        input logic          tx_nfull,
        input logic          rx_ovf,
        input logic          rx_unf,
        input logic          tx_empty,
        input logic [1:0]    ien,
        input logic [CW-1:0] rx_count
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (addr)
            REG_STAT: begin
                r[STAT_RX_NEMPTY] = rx_nempty;
                r[STAT_TX_NFULL]  = tx_nfull;
                r[STAT_RX_OVF]    = rx_ovf;
                r[STAT_RX_UNF]    = rx_unf;
                r[STAT_TX_EMPTY]  = tx_empty;
            end
            REG_IEN:   r[1:0] = ien;
            REG_COUNT: r[CW-1:0] = rx_count;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Host side: sticky flags (set wins over clear), IEN and read register
    always_comb begin
        h_ien_d  = h_ien_q;
        h_rsel_d = h_rsel_q;
        h_rreg_d = h_rreg_q;
        if (h_wr && h_addr == REG_IEN) begin
            h_ien_d = h_wdata[1:0];
        end
        h_ovf_d = h_ovf_q & ~(h_wr && h_addr == REG_STAT && h_wdata[STAT_RX_OVF]);
        h_unf_d = h_unf_q & ~(h_wr && h_addr == REG_STAT && h_wdata[STAT_RX_UNF]);
        if (c_push && c2h_full && !h_pop) h_ovf_d = 1'b1;
        if (h_pop && c2h_empty)           h_unf_d = 1'b1;
        if (h_rd) begin
            h_rsel_d = (h_addr == REG_DATA);
            h_rreg_d = reg_read(h_addr, ~c2h_empty, ~h2c_full, h_ovf_q, h_unf_q,
                                h2c_empty, h_ien_q, c2h_count);
        end
    end

    // 6809 side: sticky flags (set wins over clear), IEN and read register
    always_comb begin
        c_ien_d  = c_ien_q;
        c_rsel_d = c_rsel_q;
        c_rreg_d = c_rreg_q;
        if (c_wr && c_addr == REG_IEN) begin
            c_ien_d = c_wdata[1:0];
        end
        c_ovf_d = c_ovf_q & ~(c_wr && c_addr == REG_STAT && c_wdata[STAT_RX_OVF]);
        c_unf_d = c_unf_q & ~(c_wr && c_addr == REG_STAT && c_wdata[STAT_RX_UNF]);
        if (h_push && h2c_full && !c_pop) c_ovf_d = 1'b1;
        if (c_pop && h2c_empty)           c_unf_d = 1'b1;
        if (c_rd) begin
            c_rsel_d = (c_addr == REG_DATA);
            c_rreg_d = reg_read(c_addr, ~h2c_empty, ~c2h_full, c_ovf_q, c_unf_q,
                                c2h_empty, c_ien_q, h2c_count);
        end
    end

    // Per-side register state
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            h_ien_q  <= '0;
            c_ien_q  <= '0;
            h_ovf_q  <= 1'b0;
            h_unf_q  <= 1'b0;
            c_ovf_q  <= 1'b0;
            c_unf_q  <= 1'b0;
            h_rsel_q <= 1'b0;
            c_rsel_q <= 1'b0;
            h_rreg_q <= '0;
            c_rreg_q <= '0;
        end else begin
            h_ien_q  <= h_ien_d;
            c_ien_q  <= c_ien_d;
            h_ovf_q  <= h_ovf_d;
            h_unf_q  <= h_unf_d;
            c_ovf_q  <= c_ovf_d;
            c_unf_q  <= c_unf_d;
            h_rsel_q <= h_rsel_d;
            c_rsel_q <= c_rsel_d;
            h_rreg_q <= h_rreg_d;
            c_rreg_q <= c_rreg_d;
        end
    end

    // Read data is a select between two registers, so it holds until the next rd strobe
    assign h_rdata = h_rsel_q ? c2h_dout : h_rreg_q;
    assign c_rdata = c_rsel_q ? h2c_dout : c_rreg_q;

    // Interrupts are combinational only from registered state, so they cannot glitch
    assign _irq_host = ~((h_ien_q[IEN_RX_NEMPTY] & ~c2h_empty) | (h_ien_q[IEN_TX_EMPTY] & h2c_empty));
    assign _irq_09   = ~((c_ien_q[IEN_RX_NEMPTY] & ~h2c_empty) | (c_ien_q[IEN_TX_EMPTY] & c2h_empty));

`ifdef COPRO_MAILBOX_NMI_EN
    logic [7:0] nmi_cnt_q, nmi_cnt_d;
    logic       nmi_n_q, nmi_n_d;

    // Doorbell reloads the counter, so a repeat ring extends the pulse instead of adding an edge
    always_comb begin
        nmi_cnt_d = nmi_cnt_q;
        if (h_wr && h_addr == REG_COUNT) begin
            nmi_cnt_d = 8'(NMI_PULSE);
        end else if (nmi_cnt_q != 8'd0) begin
            nmi_cnt_d = nmi_cnt_q - 8'd1;
        end
        nmi_n_d = (nmi_cnt_d == 8'd0);
    end

    // NMI counter and registered active-low output
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            nmi_cnt_q <= 8'd0;
            nmi_n_q   <= 1'b1;
        end else begin
            nmi_cnt_q <= nmi_cnt_d;
            nmi_n_q   <= nmi_n_d;
        end
    end

    assign _nmi_09 = nmi_n_q;
`else
    assign _nmi_09 = 1'b1;
`endif

endmodule

// File: tb/tb_copro_mailbox.sv
// Directed bench for copro_mailbox with a data scoreboard for the H2C path.
module tb_copro_mailbox;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int NMI_PULSE  = 4;

  logic             clock = 1'b0;
  logic             _reset;
  logic             h_wr, h_rd, c_wr, c_rd;
  logic [1:0]       h_addr, c_addr;
  logic [WIDTH-1:0] h_wdata, c_wdata, h_rdata, c_rdata;
  logic             _irq_host, _irq_09, _nmi_09;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] exp_v;
  int               low;

  copro_mailbox #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .NMI_PULSE(NMI_PULSE)) dut (
    .clock    (clock),
    ._reset   (_reset),
    .h_wr     (h_wr),
    .h_rd     (h_rd),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_rdata  (h_rdata),
    .c_wr     (c_wr),
    .c_rd     (c_rd),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    ._irq_host(_irq_host),
    ._irq_09  (_irq_09),
    ._nmi_09  (_nmi_09)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks: strobes are raised on a falling edge and dropped one cycle later
  task automatic host_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clock);
    h_wr = 1'b1; h_addr = a; h_wdata = d;
    @(negedge clock);
    h_wr = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [WIDTH-1:0] d);
    @(negedge clock);
    h_rd = 1'b1; h_addr = a;
    @(negedge clock);
    h_rd = 1'b0;
    d = h_rdata;
  endtask

  task automatic copro_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clock);
    c_wr = 1'b1; c_addr = a; c_wdata = d;
    @(negedge clock);
    c_wr = 1'b0;
  endtask

  task automatic copro_read(input logic [1:0] a, output logic [WIDTH-1:0] d);
    @(negedge clock);
    c_rd = 1'b1; c_addr = a;
    @(negedge clock);
    c_rd = 1'b0;
    d = c_rdata;
  endtask

  // Ring the doorbell, optionally again at cycle second_at, and count low samples (bounded)
  task automatic nmi_pulse_len(input int second_at, output int n_low);
    n_low = 0;
    @(negedge clock);
    h_wr = 1'b1; h_addr = 2'd3; h_wdata = '0;
    @(negedge clock);
    h_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (_nmi_09 == 1'b0) n_low++;
      else break;
      if (i == second_at - 1) begin
        h_wr = 1'b1; h_addr = 2'd3;
      end else begin
        h_wr = 1'b0;
      end
      @(negedge clock);
    end
    h_wr = 1'b0;
  endtask

  initial begin
    _reset = 1'b0;
    h_wr = 0; h_rd = 0; h_addr = 0; h_wdata = 0;
    c_wr = 0; c_rd = 0; c_addr = 0; c_wdata = 0;

    // 1. reset state
    repeat (2) @(negedge clock);
    check("rst_h_rdata", h_rdata, 8'h00);
    check("rst_c_rdata", c_rdata, 8'h00);
    check("rst_irq_host", _irq_host, 1'b1);
    check("rst_irq_09", _irq_09, 1'b1);
    check("rst_nmi_09", _nmi_09, 1'b1);
    _reset = 1'b1;
    host_read(2'd1, rd);  check("rst_h_stat", rd, 8'h12);
    copro_read(2'd1, rd); check("rst_c_stat", rd, 8'h12);

    // 2. two pushes, count, ordered pops
    host_write(2'd0, 8'hA5); exp_q.push_back(8'hA5);
    host_write(2'd0, 8'h5A); exp_q.push_back(8'h5A);
    copro_read(2'd3, rd); check("c_count_2", rd, 8'd2);
    copro_read(2'd0, rd); exp_v = exp_q.pop_front(); check("c_pop_a5", rd, exp_v);
    copro_read(2'd0, rd); exp_v = exp_q.pop_front(); check("c_pop_5a", rd, exp_v);
    repeat (3) @(negedge clock);
    check("c_rdata_hold", c_rdata, 8'h5A);
    copro_read(2'd1, rd); check("c_stat_drained", rd, 8'h12);

    // underflow and clear
    copro_read(2'd0, rd); check("c_pop_empty", rd, 8'h00);
    copro_read(2'd1, rd); check("c_stat_unf", rd, 8'h1A);
    host_read(2'd1, rd);  check("h_stat_no_unf", rd, 8'h12);
    copro_write(2'd1, 8'h08);
    copro_read(2'd1, rd); check("c_stat_unf_clr", rd, 8'h12);

    // 3. fill to 16, 17th overflows
    for (int i = 0; i < 16; i++) begin
      host_write(2'd0, 8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
    end
    host_write(2'd0, 8'hEE);
    copro_read(2'd1, rd); check("c_stat_ovf", rd, 8'h17);
    copro_read(2'd3, rd); check("c_count_16", rd, 8'd16);
    host_read(2'd1, rd);  check("h_stat_full", rd, 8'h00);
    copro_write(2'd1, 8'h04);
    copro_read(2'd1, rd); check("c_stat_ovf_clr", rd, 8'h13);

    // 5. same-cycle push and pop on a full FIFO
    @(negedge clock);
    h_wr = 1'b1; h_addr = 2'd0; h_wdata = 8'h77;
    c_rd = 1'b1; c_addr = 2'd0;
    @(negedge clock);
    h_wr = 1'b0; c_rd = 1'b0;
    exp_v = exp_q.pop_front(); check("full_pushpop_data", c_rdata, exp_v);
    exp_q.push_back(8'h77);
    copro_read(2'd3, rd); check("full_pushpop_count", rd, 8'd16);
    copro_read(2'd1, rd); check("full_pushpop_no_ovf", rd, 8'h13);
    for (int i = 0; i < 16; i++) begin
      copro_read(2'd0, rd);
      exp_v = exp_q.pop_front();
      check($sformatf("drain_%0d", i), rd, exp_v);
    end
    check("last_is_77", rd, 8'h77);
    copro_read(2'd1, rd); check("c_stat_after_drain", rd, 8'h12);

    // 4. 6809 rx interrupt
    copro_write(2'd2, 8'h01);
    check("irq09_idle", _irq_09, 1'b1);
    host_write(2'd0, 8'h33);
    check("irq09_low_after_push", _irq_09, 1'b0);
    copro_read(2'd2, rd); check("c_ien_rb", rd, 8'h01);
    copro_read(2'd0, rd); check("c_pop_33", rd, 8'h33);
    check("irq09_high_after_pop", _irq_09, 1'b1);
    copro_write(2'd2, 8'h00);

    // host tx-empty interrupt and IEN upper bits
    host_write(2'd2, 8'hFF);
    check("irq_host_tx_empty", _irq_host, 1'b0);
    host_read(2'd2, rd); check("h_ien_masked", rd, 8'h03);
    host_write(2'd2, 8'h00);
    check("irq_host_off", _irq_host, 1'b1);

    // C2H direction
    copro_write(2'd0, 8'h3C);
    host_read(2'd3, rd); check("h_count_1", rd, 8'd1);
    host_read(2'd1, rd); check("h_stat_rx", rd, 8'h13);
    host_read(2'd0, rd); check("h_pop_3c", rd, 8'h3C);
    host_read(2'd1, rd); check("h_stat_rx_empty", rd, 8'h12);

    // 6. doorbell
`ifdef COPRO_MAILBOX_NMI_EN
    nmi_pulse_len(-1, low); check("nmi_single_len", low, 4);
    repeat (3) @(negedge clock);
    nmi_pulse_len(2, low);  check("nmi_extended_len", low, 6);
    repeat (3) @(negedge clock);
    host_write(2'd3, 8'h00);
    check("nmi_low_before_rst", _nmi_09, 1'b0);
    #2 _reset = 1'b0;
    #1 check("nmi_async_rst", _nmi_09, 1'b1);
    check("h_rdata_async_rst", h_rdata, 8'h00);
    @(negedge clock);
    _reset = 1'b1;
`else
    host_write(2'd3, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("nmi_idle_%0d", i), _nmi_09, 1'b1);
      @(negedge clock);
    end
`endif
    host_read(2'd3, rd); check("h_count_after_doorbell", rd, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
